ex_stage: RTL and testbench



---
 rtl/ex_stage_if.sv | 22 ++
 rtl/ex_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Data SRAM request bundle driven by the execute stage.
// master: ex_stage drives en/wen/addr/wdata; slave: memory side.
interface ex_stage_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata
  );

  modport slave (
    input data_sram_en,
    input data_sram_wen,
    input data_sram_addr,
    input data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, data SRAM request,
// 32-step DIV/DIVU engine with HI/LO and MFHI/MFLO readout.
// Ports: clk, rst (sync, high), flush, stall vector, id_to_ex_bus in;
// ex_to_mem_bus, sram (data SRAM request), stallreq_for_ex out.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  ex_stage_if.master              sram,
  output logic                    stallreq_for_ex
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } div_st_e;

  logic [ID_TO_EX_WD-1:0] bus_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
    end else if (flush) begin
      bus_q <= '0;
    end else if (stall[2] && !stall[3]) begin
      bus_q <= '0;
    end else if (!stall[2]) begin
      bus_q <= id_to_ex_bus;
    end
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign pc         = bus_q[158:127];
  assign inst       = bus_q[126:95];
  assign alu_op     = bus_q[94:83];
  assign sel_src1   = bus_q[82:80];
  assign sel_src2   = bus_q[79:76];
  assign ram_en     = bus_q[75];
  assign ram_wen    = bus_q[74:71];
  assign rf_we      = bus_q[70];
  assign rf_waddr   = bus_q[69:65];
  assign sel_rf_res = bus_q[64];
  assign rdata1     = bus_q[63:32];
  assign rdata2     = bus_q[31:0];

  logic unused_bits;
  assign unused_bits = ^{stall[STALL_WD-1:4], stall[1:0],
                         inst[25:16]};

  logic op_special, is_div, is_divu, is_mfhi, is_mflo, div_any;
  assign op_special = (inst[31:26] == 6'd0);
  assign is_div     = op_special && (inst[5:0] == 6'h1A);
  assign is_divu    = op_special && (inst[5:0] == 6'h1B);
  assign is_mfhi    = op_special && (inst[5:0] == 6'h10);
  assign is_mflo    = op_special && (inst[5:0] == 6'h12);
  assign div_any    = is_div || is_divu;

  logic [31:0] src1, src2, alu_res;

  always_comb begin
    src1 = '0;
    unique case (1'b1)
      sel_src1[0]: src1 = rdata1;
      sel_src1[1]: src1 = pc;
      sel_src1[2]: src1 = {27'b0, inst[10:6]};
      default:     src1 = '0;
    endcase
  end

  always_comb begin
    src2 = '0;
    unique case (1'b1)
      sel_src2[0]: src2 = rdata2;
      sel_src2[1]: src2 = {{16{inst[15]}}, inst[15:0]};
      sel_src2[2]: src2 = 32'd8;
      sel_src2[3]: src2 = {16'b0, inst[15:0]};
      default:     src2 = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      alu_op[11]: alu_res = src1 + src2;
      alu_op[10]: alu_res = src1 - src2;
      alu_op[9]:  alu_res = {31'b0,
                    $signed(src1) < $signed(src2)};
      alu_op[8]:  alu_res = {31'b0, src1 < src2};
      alu_op[7]:  alu_res = src1 & src2;
      alu_op[6]:  alu_res = ~(src1 | src2);
      alu_op[5]:  alu_res = src1 | src2;
      alu_op[4]:  alu_res = src1 ^ src2;
      alu_op[3]:  alu_res = src2 << src1[4:0];
      alu_op[2]:  alu_res = src2 >> src1[4:0];
      alu_op[1]:  alu_res = $signed(src2) >>> src1[4:0];
      alu_op[0]:  alu_res = {src2[15:0], 16'b0};
      default:    alu_res = '0;
    endcase
  end

  div_st_e     state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] dvd_q, dvd_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // One restoring step: shift next dividend bit into the partial
  // remainder, subtract the divisor if it fits.
  logic [32:0] trial, diff;
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (div_any) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = (is_div && rdata1[31]) ? -rdata1 : rdata1;
          dsr_d   = (is_div && rdata2[31]) ? -rdata2 : rdata2;
          dvd_d   = rdata1;
          negq_d  = is_div && (rdata1[31] ^ rdata2[31]);
          negr_d  = is_div && rdata1[31];
          dz_d    = (rdata2 == 32'd0);
        end
      end
      S_BUSY: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
        end else begin
          rem_d = trial[31:0];
        end
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = dvd_q;
        end else begin
          lo_d = negq_q ? -quo_q : quo_q;
          hi_d = negr_q ? -rem_q : rem_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  logic [31:0] result;

  always_comb begin
    result = alu_res;
    if (is_mfhi) begin
      result = hi_q;
    end else if (is_mflo) begin
      result = lo_q;
    end
  end

  assign stallreq_for_ex = div_any && (state_q != S_DONE);

  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res,
                          rf_we && !div_any, rf_waddr, result};

  assign sram.data_sram_en    = ram_en;
  assign sram.data_sram_wen   = ram_wen;
  assign sram.data_sram_addr  = alu_res;
  assign sram.data_sram_wdata = rdata2;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, random ALU ops,
// and division / flush / reset / stall sequences.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst, flush;
  logic [5:0]   stall, man_stall;
  logic         auto_st;
  logic [158:0] id_bus;
  logic [75:0]  ex_bus;
  logic         sreq;
  int           total = 0;
  int           bad = 0;

  ex_stage_if sif ();

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_bus),
    .sram            (sif),
    .stallreq_for_ex (sreq)
  );

  always #5 clk = ~clk;

  // Stand-in stall controller: hold decode and execute while EX asks.
  assign stall = auto_st ? {2'b0, sreq, sreq, 2'b0} : man_stall;

  typedef struct {
    string       nm;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [158:0] mk(
    input logic [31:0] pc, input logic [31:0] inst,
    input logic [11:0] op, input logic [2:0] s1,
    input logic [3:0] s2, input logic ren,
    input logic [3:0] wen, input logic rfwe,
    input logic [4:0] wa, input logic sr,
    input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ren, wen, rfwe, wa, sr, r1, r2};
  endfunction

  function automatic logic [75:0] mk_out(
    input logic [31:0] pc, input logic ren,
    input logic [3:0] wen, input logic sr, input logic rfwe,
    input logic [4:0] wa, input logic [31:0] res);
    return {pc, ren, wen, sr, rfwe, wa, res};
  endfunction

  // Reference ALU written from the operation table.
  function automatic logic [31:0] ref_alu(
    input logic [11:0] op, input logic [2:0] s1,
    input logic [3:0] s2, input logic [31:0] pc,
    input logic [31:0] inst, input logic [31:0] r1,
    input logic [31:0] r2);
    logic [31:0] a, b, imm;
    int sh;
    a = 0;
    if (s1 == 3'b001) a = r1;
    if (s1 == 3'b010) a = pc;
    if (s1 == 3'b100) a = inst[10:6];
    imm = {16'b0, inst[15:0]};
    b = 0;
    if (s2 == 4'b0001) b = r2;
    if (s2 == 4'b0010) b = imm[15] ? imm | 32'hFFFF_0000 : imm;
    if (s2 == 4'b0100) b = 8;
    if (s2 == 4'b1000) b = imm;
    sh = a % 32;
    case (op)
      12'h800: return a + b;
      12'h400: return a - b;
      12'h200: return (int'(a) < int'(b)) ? 1 : 0;
      12'h100: return (a < b) ? 1 : 0;
      12'h080: return a & b;
      12'h040: return ~(a | b);
      12'h020: return a | b;
      12'h010: return a ^ b;
      12'h008: return b << sh;
      12'h004: return b >> sh;
      12'h002: return 32'(int'(b) >>> sh);
      12'h001: return b * 65536;
      default: return 0;
    endcase
  endfunction

  task automatic ref_div(input bit sgn, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [31:0] lo,
                         output logic [31:0] hi);
    if (b == 0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (sgn) begin
      lo = 32'(int'(a) / int'(b));
      hi = 32'(int'(a) % int'(b));
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  task automatic chk(input string nm, input logic [75:0] act,
                     input logic [75:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] sp(input logic [5:0] fn,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    return mk(32'h400, {26'b0, fn}, 12'h0, 3'b0, 4'b0,
              1'b0, 4'h0, 1'b1, 5'd3, 1'b0, a, b);
  endfunction

  // Runs a division, counts stall cycles, then reads LO and HI.
  task automatic do_div(input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input string nm);
    logic [31:0] lo, hi;
    int n;
    ref_div(sgn, a, b, lo, hi);
    id_bus = sp(sgn ? 6'h1A : 6'h1B, a, b);
    tick();
    chk({nm, "_rfwe0"}, 76'(ex_bus[37]), 76'(0));
    id_bus = sp(6'h12, 0, 0);
    n = 0;
    while (sreq && n < 100) begin
      n++;
      tick();
    end
    chk({nm, "_stall_cycles"}, 76'(n), 76'(33));
    tick();
    chk({nm, "_lo"}, 76'(ex_bus[31:0]), 76'(lo));
    id_bus = sp(6'h10, 0, 0);
    tick();
    chk({nm, "_hi"}, 76'(ex_bus[31:0]), 76'(hi));
    id_bus = '0;
  endtask

  vec_t vt[$];

  initial begin
    logic [31:0] rv, r1, r2, res;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic [158:0] hb;
    bit sg;

    vt.push_back('{"ori", 12'h020, 3'b001, 4'b1000, 32'h100,
      32'h3400_0034, 32'h0000_1200, 32'h0, 1'b0, 4'h0,
      32'h0000_1234});
    vt.push_back('{"slt", 12'h200, 3'b001, 4'b0001, 32'h104,
      32'h0800_0000, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'h0, 32'h1});
    vt.push_back('{"sltu", 12'h100, 3'b001, 4'b0001, 32'h108,
      32'h0800_0000, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'h0, 32'h0});
    vt.push_back('{"sra", 12'h002, 3'b100, 4'b0001, 32'h10C,
      32'h0000_0103, 32'h0, 32'h8000_0000, 1'b0, 4'h0,
      32'hF800_0000});
    vt.push_back('{"store", 12'h800, 3'b001, 4'b0010, 32'h110,
      32'hAC00_FFFC, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF,
      32'h0000_0FFC});
    vt.push_back('{"lui", 12'h001, 3'b000, 4'b1000, 32'h114,
      32'h3C00_ABCD, 32'h0, 32'h0, 1'b0, 4'h0, 32'hABCD_0000});
    vt.push_back('{"sub", 12'h400, 3'b001, 4'b0001, 32'h118,
      32'h0800_0000, 32'h5, 32'h7, 1'b0, 4'h0, 32'hFFFF_FFFE});
    vt.push_back('{"link", 12'h800, 3'b010, 4'b0100, 32'hBFC0_0010,
      32'h0C00_0000, 32'h0, 32'h0, 1'b0, 4'h0, 32'hBFC0_0018});
    vt.push_back('{"nor", 12'h040, 3'b001, 4'b0001, 32'h11C,
      32'h0800_0000, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0, 4'h0,
      32'hF000_FF00});
    vt.push_back('{"srl", 12'h004, 3'b001, 4'b0001, 32'h120,
      32'h0800_0000, 32'h24, 32'h8000_0000, 1'b0, 4'h0,
      32'h0800_0000});
    vt.push_back('{"noop", 12'h000, 3'b001, 4'b0001, 32'h124,
      32'h0800_0000, 32'h1234, 32'h5678, 1'b0, 4'h0, 32'h0});
    vt.push_back('{"xor", 12'h010, 3'b001, 4'b0001, 32'h128,
      32'h0800_0000, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 4'h0,
      32'hF0F0_0F0F});

    rst = 1'b1;
    flush = 1'b0;
    auto_st = 1'b1;
    man_stall = '0;
    id_bus = mk(32'h1, 32'h2, 12'h800, 3'b001, 4'b0001, 1'b1,
                4'hF, 1'b1, 5'd1, 1'b1, 32'h3, 32'h4);
    tick();
    tick();
    chk("rst_bus", ex_bus, 76'(0));
    chk("rst_sram", {sif.data_sram_en, sif.data_sram_wen,
        sif.data_sram_addr, sif.data_sram_wdata}, 76'(0));
    chk("rst_sreq", 76'(sreq), 76'(0));
    rst = 1'b0;
    id_bus = sp(6'h10, 0, 0);
    tick();
    chk("rst_hi", 76'(ex_bus[31:0]), 76'(0));

    foreach (vt[i]) begin
      id_bus = mk(vt[i].pc, vt[i].inst, vt[i].op, vt[i].s1,
                  vt[i].s2, vt[i].ren, vt[i].wen, 1'b1, 5'd9,
                  1'b0, vt[i].r1, vt[i].r2);
      tick();
      chk({vt[i].nm, "_bus"}, ex_bus,
          mk_out(vt[i].pc, vt[i].ren, vt[i].wen, 1'b0, 1'b1,
                 5'd9, vt[i].exp));
      chk({vt[i].nm, "_addr"}, 76'(sif.data_sram_addr),
          76'(vt[i].exp));
      chk({vt[i].nm, "_wdata"}, 76'(sif.data_sram_wdata),
          76'(vt[i].r2));
      chk({vt[i].nm, "_en"},
          76'({sif.data_sram_en, sif.data_sram_wen}),
          76'({vt[i].ren, vt[i].wen}));
    end

    // Stall hold then bubble.
    auto_st = 1'b0;
    hb = mk(32'h200, 32'h3400_0034, 12'h020, 3'b001, 4'b1000,
            1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h1200, 32'h77);
    id_bus = hb;
    tick();
    man_stall = 6'b001100;
    id_bus = mk(32'h300, 32'h0800_0000, 12'h800, 3'b001,
                4'b0001, 1'b1, 4'h3, 1'b1, 5'd5, 1'b0, 32'h1,
                32'h2);
    tick();
    tick();
    chk("hold_bus", ex_bus,
        mk_out(32'h200, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h1234));
    man_stall = 6'b000100;
    tick();
    chk("bubble_bus", ex_bus, 76'(0));
    chk("bubble_sram", {sif.data_sram_en, sif.data_sram_wen,
        sif.data_sram_addr, sif.data_sram_wdata}, 76'(0));
    man_stall = '0;
    auto_st = 1'b1;

    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_div(1'b0, 32'd100, 32'd0, "divu_100_0");

    // Flush while BUSY at count 10.
    id_bus = sp(6'h1A, 32'd50, 32'd7);
    tick();
    id_bus = sp(6'h12, 0, 0);
    repeat (11) tick();
    chk("flush_pre_sreq", 76'(sreq), 76'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_sreq", 76'(sreq), 76'(0));
    chk("flush_bus", ex_bus, 76'(0));
    tick();
    chk("flush_lo", 76'(ex_bus[31:0]), 76'(32'hFFFF_FFFF));
    id_bus = sp(6'h10, 0, 0);
    tick();
    chk("flush_hi", 76'(ex_bus[31:0]), 76'(100));

    // Reset while BUSY clears HI/LO.
    id_bus = sp(6'h1B, 32'd7, 32'd2);
    tick();
    id_bus = sp(6'h12, 0, 0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstb_sreq", 76'(sreq), 76'(0));
    chk("rstb_bus", ex_bus, 76'(0));
    tick();
    chk("rstb_lo", 76'(ex_bus[31:0]), 76'(0));
    id_bus = sp(6'h10, 0, 0);
    tick();
    chk("rstb_hi", 76'(ex_bus[31:0]), 76'(0));

    // Random ALU traffic.
    for (int i = 0; i < 150; i++) begin
      rv = $urandom();
      op = (rv[3:0] < 12) ? 12'(1 << rv[3:0]) : 12'h0;
      s1 = (rv[5:4] == 0) ? 3'b0 : 3'(1 << (rv[5:4] - 1));
      s2 = 4'(1 << rv[7:6]);
      r1 = $urandom();
      r2 = $urandom();
      rv = $urandom();
      hb = mk($urandom(), {6'h08, rv[25:0]}, op, s1, s2,
              r1[0], r2[3:0], r1[1], r1[6:2], r2[4], r1, r2);
      id_bus = hb;
      tick();
      res = ref_alu(op, s1, s2, hb[158:127], {6'h08, rv[25:0]},
                    r1, r2);
      chk("rnd_bus", ex_bus,
          mk_out(hb[158:127], r1[0], r2[3:0], r2[4], r1[1],
                 r1[6:2], res));
      chk("rnd_sram", {sif.data_sram_en, sif.data_sram_wen,
          sif.data_sram_addr, sif.data_sram_wdata},
          {r1[0], r2[3:0], res, r2});
    end

    // Random divisions.
    for (int i = 0; i < 8; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      rv = $urandom();
      if (rv[1:0] == 0) r2 = 0;
      if (rv[1:0] == 1) r2 = r2 % 17;
      sg = rv[2];
      if (sg && r1 == 32'h8000_0000 && r2 == 32'hFFFF_FFFF)
        r2 = 32'd3;
      do_div(sg, r1, r2, "rnd_div");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
